// File: rtl/hd44780_bus_decoder_if.sv
// hd44780_bus_decoder_if: LCD pin bundle plus decoded-event stream
interface hd44780_bus_decoder_if;
  logic       lcd_rs_i;
  logic       lcd_e_i;
  logic [7:0] lcd_databus_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic       evt_rs_o;
  logic [7:0] evt_data_o;
  modport master (
    output lcd_rs_i, lcd_e_i, lcd_databus_i, evt_ready_i,
    input  evt_valid_o, evt_rs_o, evt_data_o
  );
  modport slave (
    input  lcd_rs_i, lcd_e_i, lcd_databus_i, evt_ready_i,
    output evt_valid_o, evt_rs_o, evt_data_o
  );
endinterface

// File: rtl/hd44780_bus_decoder.sv
// hd44780_bus_decoder: passive HD44780 write decoder with 2-row shadow buffer and event FIFO
module hd44780_bus_decoder #(
  parameter int         SYNC_STAGES    = 2,
  parameter int         NUM_OF_CHARS   = 16,
  parameter logic [6:0] LCD_ROW_OFFSET = 7'h40,
  parameter int         EVT_DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hd44780_bus_decoder_if.slave  bus,
  input  logic [4:0]            rd_addr_i,
  output logic [7:0]            rd_char_o,
  output logic [6:0]            cursor_o,
  output logic                  busy_o,
  output logic                  oor_o,
  output logic                  ovf_o
);
  localparam int         CELLS = 2 * NUM_OF_CHARS;
  localparam int         AW    = $clog2(EVT_DEPTH);
  localparam logic [6:0] N7    = 7'(NUM_OF_CHARS);
  localparam logic [4:0] LAST  = 5'(CELLS - 1);
  typedef enum logic {IDLE, CLEAR} state_e;
  logic [1:0]                    rst_sync_q;
  logic                          rst_n;
  logic [SYNC_STAGES-1:0]        e_sync_q, rs_sync_q;
  logic [SYNC_STAGES-1:0][7:0]   db_sync_q;
  logic                          e_last_q, rs_last_q;
  logic [7:0]                    db_last_q;
  logic                          fall;
  logic                          txn_vld_q;
  logic [8:0]                    txn_q;
  state_e                        state_q, state_d;
  logic [4:0]                    clr_idx_q, clr_idx_d;
  logic [6:0]                    ac_q, ac_d;
  logic                          id_q, id_d;
  logic                          pend_vld_q, pend_vld_d;
  logic [8:0]                    pend_q, pend_d;
  logic                          oor_q, oor_d, ovf_q, ovf_d;
  logic                          ap_vld;
  logic [8:0]                    ap;
  logic                          sh_we;
  logic [4:0]                    sh_idx;
  logic [7:0]                    sh_data;
  logic                          in_row0, in_row1;
  logic [6:0]                    rel;
  logic [7:0]                    shadow_q [CELLS];
  logic [7:0]                    rd_char_q;
  logic [8:0]                    fifo_q [EVT_DEPTH];
  logic [AW:0]                   wr_q, rd_q;
  logic                          full, empty, pop, push;
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
  endfunction
  // Reset asserts immediately but releases in step with the clock
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  // Synchronise the pins, remember the last synced sample and flag an E fall for the next cycle
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      e_sync_q  <= '0;
      rs_sync_q <= '0;
      db_sync_q <= '0;
      e_last_q  <= 1'b0;
      rs_last_q <= 1'b0;
      db_last_q <= '0;
      txn_vld_q <= 1'b0;
      txn_q     <= '0;
    end else begin
      e_sync_q  <= {e_sync_q[SYNC_STAGES-2:0], bus.lcd_e_i};
      rs_sync_q <= {rs_sync_q[SYNC_STAGES-2:0], bus.lcd_rs_i};
      db_sync_q <= {db_sync_q[SYNC_STAGES-2:0], bus.lcd_databus_i};
      e_last_q  <= e_sync_q[SYNC_STAGES-1];
      rs_last_q <= rs_sync_q[SYNC_STAGES-1];
      db_last_q <= db_sync_q[SYNC_STAGES-1];
      txn_vld_q <= fall;
      if (fall) txn_q <= {rs_last_q, db_last_q};
    end
  assign fall = e_last_q & ~e_sync_q[SYNC_STAGES-1];
  assign in_row0 = ac_q < N7;
  assign in_row1 = (ac_q >= LCD_ROW_OFFSET) && (ac_q < 7'(LCD_ROW_OFFSET + N7));
  assign rel     = ac_q - LCD_ROW_OFFSET;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = wr_q == rd_q;
  assign pop     = ~empty & bus.evt_ready_i;
  assign push    = ap_vld & (~full | pop);
  // Clear sequencing, pending slot and transaction decode; only IDLE applies transactions
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ac_d       = ac_q;
    id_d       = id_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    oor_d      = oor_q;
    ovf_d      = ovf_q;
    sh_we      = 1'b0;
    sh_idx     = clr_idx_q;
    sh_data    = 8'h20;
    ap_vld     = 1'b0;
    ap         = txn_q;
    if (state_q == CLEAR) begin
      sh_we     = 1'b1;
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q == LAST) state_d = IDLE;
      if (txn_vld_q && pend_vld_q) ovf_d = 1'b1;
      if (txn_vld_q && !pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_d     = txn_q;
      end
    end else begin
      ap_vld     = pend_vld_q | txn_vld_q;
      ap         = pend_vld_q ? pend_q : txn_q;
      pend_vld_d = pend_vld_q & txn_vld_q;
      pend_d     = txn_q;
      if (ap_vld && ap[8]) begin
        sh_we   = in_row0 | in_row1;
        sh_idx  = in_row0 ? ac_q[4:0] : 5'(rel + N7);
        sh_data = ap[7:0];
        oor_d   = oor_q | ~(in_row0 | in_row1);
        ac_d    = ac_step(ac_q, id_q);
      end
      if (ap_vld && !ap[8]) begin
        if (ap[7]) ac_d = ap[6:0];
        if (ap[7:2] == 6'b000001) id_d = ap[1];
        if (ap[7:1] == 7'b0000001) ac_d = '0;
        if (ap[7:0] == 8'h01) begin
          ac_d      = '0;
          id_d      = 1'b1;
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
    end
    if (ap_vld && full && !pop) ovf_d = 1'b1;
  end
  // Control state register
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_idx_q  <= '0;
      ac_q       <= '0;
      id_q       <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      oor_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      oor_q      <= oor_d;
      ovf_q      <= ovf_d;
    end
  // Shadow buffer write and registered read (read sees the pre-write value)
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) shadow_q[i] <= 8'h20;
      rd_char_q <= 8'h20;
    end else begin
      rd_char_q <= shadow_q[rd_addr_i];
      if (sh_we) shadow_q[sh_idx] <= sh_data;
    end
  // Event FIFO; a pop frees the slot for a push in the same cycle
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < EVT_DEPTH; i++) fifo_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) fifo_q[wr_q[AW-1:0]] <= ap;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  assign {bus.evt_rs_o, bus.evt_data_o} = fifo_q[rd_q[AW-1:0]];
  assign bus.evt_valid_o = ~empty;
  assign rd_char_o = rd_char_q;
  assign cursor_o  = ac_q;
  assign busy_o    = state_q == CLEAR;
  assign oor_o     = oor_q;
  assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_hd44780_bus_decoder.sv
// tb_hd44780_bus_decoder: randomized bench against a behavioural LCD model
module tb_hd44780_bus_decoder;
  logic       clk = 0, rst_n = 0;
  logic [4:0] rd_addr = 0;
  logic [7:0] rd_char;
  logic [6:0] cursor;
  logic       busy, oor, ovf;
  int         checks = 0, errors = 0;
  bit         drain = 1;
  logic [7:0] m_sh [32];
  logic [6:0] m_ac;
  bit         m_id, m_oor, m_ovf;
  logic [8:0] m_q [$];
  hd44780_bus_decoder_if b();
  hd44780_bus_decoder dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(b), .rd_addr_i(rd_addr),
    .rd_char_o(rd_char), .cursor_o(cursor), .busy_o(busy), .oor_o(oor), .ovf_o(ovf)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task m_reset;
    for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
    m_ac = 0; m_id = 1; m_oor = 0; m_ovf = 0;
    m_q.delete();
  endtask
  function automatic logic [6:0] m_step(logic [6:0] a, bit inc);
    if (inc) return a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1;
    return a == 7'h40 ? 7'h27 : a == 7'h00 ? 7'h67 : a - 7'd1;
  endfunction
  task m_apply(input bit rs, input logic [7:0] d);
    int a;
    a = int'(m_ac);
    if (rs) begin
      if (a < 16) m_sh[a] = d;
      else if (a >= 64 && a < 80) m_sh[a - 48] = d;
      else m_oor = 1;
      m_ac = m_step(m_ac, m_id);
    end else if (d >= 128) m_ac = d[6:0];
    else if (d < 8) begin
      if (d >= 4) m_id = d[1];
      else if (d >= 2) m_ac = 0;
      else if (d == 1) begin
        m_ac = 0; m_id = 1;
        for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
      end
    end
    if (m_q.size() < 4) m_q.push_back({rs, d});
    else m_ovf = 1;
  endtask
  function automatic logic [8:0] rand_txn();
    logic [7:0] d;
    d = 8'($urandom);
    case ($urandom_range(0, 7))
      0: return {1'b0, 8'h80 | d};
      1: return {1'b0, 8'h80 | 8'($urandom_range(0, 1) * 64) | 8'($urandom_range(0, 17))};
      2: return {1'b0, 8'h04 | (d & 8'h03)};
      3: return {1'b0, 8'h02};
      4: return {1'b0, d == 8'h01 ? 8'h38 : d};
      default: return {1'b1, d};
    endcase
  endfunction
  task pulse(input bit rs, input logic [7:0] d);
    @(posedge clk); #1;
    b.lcd_rs_i = rs; b.lcd_databus_i = d; b.lcd_e_i = 1;
    repeat (4) @(posedge clk);
    #1;
    b.lcd_e_i = 0; b.lcd_rs_i = 1'($urandom); b.lcd_databus_i = 8'($urandom);
  endtask
  task send(input bit rs, input logic [7:0] d);
    pulse(rs, d);
    m_apply(rs, d);
    repeat (6) @(posedge clk);
    if (drain) begin
      @(negedge clk);
      checks++;
      if (b.evt_valid_o !== 1'b1 || {b.evt_rs_o, b.evt_data_o} !== m_q[0]) begin
        errors++;
        $display("FAIL evt_head: got valid=%b %h required %h", b.evt_valid_o, {b.evt_rs_o, b.evt_data_o}, m_q[0]);
      end
      b.evt_ready_i = 1;
      @(posedge clk); #1;
      b.evt_ready_i = 0;
      void'(m_q.pop_front());
    end
  endtask
  task rd_cell(input int i, output logic [7:0] v);
    @(negedge clk);
    rd_addr = 5'(i);
    @(negedge clk);
    v = rd_char;
  endtask
  task test_reset;
    logic [7:0] v;
    b.lcd_e_i = 0; b.lcd_rs_i = 0; b.lcd_databus_i = 0; b.evt_ready_i = 0;
    rst_n = 0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    checks++;
    if ({cursor, busy, b.evt_valid_o, oor, ovf} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got cursor=%h busy=%b valid=%b oor=%b ovf=%b required all 0", cursor, busy, b.evt_valid_o, oor, ovf);
    end
    for (int i = 0; i < 32; i++) begin
      rd_cell(i, v);
      checks++;
      if (v !== 8'h20) begin
        errors++;
        $display("FAIL reset_cell[%0d]: got %h required 20", i, v);
      end
    end
  endtask
  task test_hitachi;
    logic [7:0] v;
    string s;
    s = "HITACHI";
    send(0, 8'h80);
    for (int i = 0; i < s.len(); i++) send(1, s[i]);
    send(0, 8'hC0);
    send(1, 8'hCB); send(1, 8'hC0); send(1, 8'hC1);
    for (int i = 0; i < 32; i++) begin
      rd_cell(i, v);
      checks++;
      if (v !== m_sh[i]) begin
        errors++;
        $display("FAIL hitachi_cell[%0d]: got %h required %h", i, v, m_sh[i]);
      end
    end
    checks++;
    if (cursor !== 7'h43) begin
      errors++;
      $display("FAIL hitachi_cursor: got %h required 43", cursor);
    end
  endtask
  task test_oor_entry;
    logic [7:0] v;
    send(0, 8'hA7);
    send(1, 8'h41);
    @(negedge clk);
    checks++;
    if (oor !== 1'b1 || cursor !== 7'h40) begin
      errors++;
      $display("FAIL oor_wrap: got oor=%b cursor=%h required oor=1 cursor=40", oor, cursor);
    end
    send(0, 8'h04);
    send(1, 8'hCB);
    @(negedge clk);
    checks++;
    if (cursor !== 7'h27) begin
      errors++;
      $display("FAIL dec_wrap: got cursor=%h required 27", cursor);
    end
    for (int i = 0; i < 32; i++) begin
      rd_cell(i, v);
      checks++;
      if (v !== m_sh[i]) begin
        errors++;
        $display("FAIL oor_cell[%0d]: got %h required %h", i, v, m_sh[i]);
      end
    end
    send(0, 8'h06);
  endtask
  task drain_all(input string tag);
    int n;
    n = m_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (b.evt_valid_o !== 1'b1 || {b.evt_rs_o, b.evt_data_o} !== m_q[0]) begin
        errors++;
        $display("FAIL %s_pop[%0d]: got valid=%b %h required %h", tag, i, b.evt_valid_o, {b.evt_rs_o, b.evt_data_o}, m_q[0]);
      end
      b.evt_ready_i = 1;
      @(posedge clk); #1;
      b.evt_ready_i = 0;
      void'(m_q.pop_front());
    end
    @(negedge clk);
    checks++;
    if (b.evt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: got valid=%b required 0", tag, b.evt_valid_o);
    end
  endtask
  task test_fifo_simul;
    logic [8:0] t;
    drain = 0;
    for (int i = 0; i < 4; i++) begin
      t = rand_txn();
      send(t[8], t[7:0]);
    end
    t = rand_txn();
    pulse(t[8], t[7:0]);
    repeat (3) @(posedge clk);
    #1;
    b.evt_ready_i = 1;
    @(negedge clk);
    checks++;
    if ({b.evt_rs_o, b.evt_data_o} !== m_q[0]) begin
      errors++;
      $display("FAIL simul_head: got %h required %h", {b.evt_rs_o, b.evt_data_o}, m_q[0]);
    end
    @(posedge clk); #1;
    b.evt_ready_i = 0;
    void'(m_q.pop_front());
    m_apply(t[8], t[7:0]);
    repeat (4) @(negedge clk);
    checks++;
    if (ovf !== 1'b0 || m_ovf) begin
      errors++;
      $display("FAIL simul_ovf: got %b required 0", ovf);
    end
    drain_all("simul");
    drain = 1;
  endtask
  task test_fifo_overflow;
    logic [8:0] t;
    drain = 0;
    for (int i = 0; i < 5; i++) begin
      t = rand_txn();
      send(t[8], t[7:0]);
    end
    @(negedge clk);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL fifo_ovf: got %b required 1", ovf);
    end
    drain_all("ovf");
    drain = 1;
  endtask
  task test_clear;
    logic [7:0] v;
    int n, cnt;
    send(0, 8'h80);
    for (int i = 0; i < 16; i++) send(1, 8'($urandom_range(33, 126)));
    pulse(0, 8'h01);
    m_apply(0, 8'h01);
    n = 0;
    @(negedge clk);
    while (!busy && n < 20) begin @(negedge clk); n++; end
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt !== 32) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d cycles required 32", cnt);
    end
    drain_all("clear");
    for (int i = 0; i < 32; i++) begin
      rd_cell(i, v);
      checks++;
      if (v !== m_sh[i]) begin
        errors++;
        $display("FAIL clear_cell[%0d]: got %h required %h", i, v, m_sh[i]);
      end
    end
    checks++;
    if (cursor !== 7'h00) begin
      errors++;
      $display("FAIL clear_cursor: got %h required 00", cursor);
    end
    send(1, 8'h41); send(1, 8'h42);
    drain = 0;
    pulse(0, 8'h01);
    m_apply(0, 8'h01);
    repeat (4) @(posedge clk);
    pulse(1, 8'h5A);
    m_apply(1, 8'h5A);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy_pending: got %b required 1", busy);
    end
    n = 0;
    while (busy && n < 64) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    checks++;
    if (cursor !== m_ac || busy !== 1'b0) begin
      errors++;
      $display("FAIL pending_cursor: got cursor=%h busy=%b required %h 0", cursor, busy, m_ac);
    end
    for (int i = 0; i < 32; i++) begin
      rd_cell(i, v);
      checks++;
      if (v !== m_sh[i]) begin
        errors++;
        $display("FAIL pending_cell[%0d]: got %h required %h", i, v, m_sh[i]);
      end
    end
    drain_all("pending");
    drain = 1;
  endtask
  task test_random;
    logic [7:0] v;
    logic [8:0] t;
    for (int k = 0; k < 40; k++) begin
      t = rand_txn();
      send(t[8], t[7:0]);
    end
    @(negedge clk);
    checks++;
    if (cursor !== m_ac || oor !== m_oor || ovf !== m_ovf) begin
      errors++;
      $display("FAIL random_state: got cursor=%h oor=%b ovf=%b required %h %b %b", cursor, oor, ovf, m_ac, m_oor, m_ovf);
    end
    for (int i = 0; i < 32; i++) begin
      rd_cell(i, v);
      checks++;
      if (v !== m_sh[i]) begin
        errors++;
        $display("FAIL random_cell[%0d]: got %h required %h", i, v, m_sh[i]);
      end
    end
  endtask
  task test_reset_mid;
    logic [7:0] v;
    int n;
    drain = 0;
    pulse(0, 8'h01);
    m_apply(0, 8'h01);
    n = 0;
    while (!busy && n < 20) begin @(posedge clk); n++; end
    repeat (10) @(posedge clk);
    #1;
    b.lcd_rs_i = 1; b.lcd_databus_i = 8'h51; b.lcd_e_i = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    m_reset();
    checks++;
    if ({cursor, busy, b.evt_valid_o, oor, ovf} !== 11'b0 || rd_char !== 8'h20) begin
      errors++;
      $display("FAIL mid_reset: got cursor=%h busy=%b valid=%b oor=%b ovf=%b rd=%h required 0s rd=20", cursor, busy, b.evt_valid_o, oor, ovf, rd_char);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    b.lcd_e_i = 0;
    m_apply(1, 8'h51);
    repeat (8) @(negedge clk);
    checks++;
    if (cursor !== m_ac || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_cursor: got %h busy=%b required %h 0", cursor, busy, m_ac);
    end
    for (int i = 0; i < 32; i++) begin
      rd_cell(i, v);
      checks++;
      if (v !== m_sh[i]) begin
        errors++;
        $display("FAIL post_reset_cell[%0d]: got %h required %h", i, v, m_sh[i]);
      end
    end
    drain_all("post_reset");
    drain = 1;
  endtask
  initial begin
    test_reset();
    test_hitachi();
    test_oor_entry();
    test_fifo_simul();
    test_fifo_overflow();
    test_clear();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
